// File: rtl/flop_pipe_pkg.sv
// flop_pipe_pkg: shared constants and helpers for the flop_pipe register pipeline.
//   WIDTH_MAX / DEPTH_MAX : upper limits of the WIDTH and DEPTH parameters.
//   cnt_width(depth)      : bit width of the occupancy counter, $clog2(depth+1).
package flop_pipe_pkg;

  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MAX = 16;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_stage.sv
// flop_pipe_stage: one valid+data slot of the pipeline.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears valid and data)
//   flush_i     : synchronous clear of the valid bit
//   adv_i       : stage advances this cycle (takes the upstream word or a bubble)
//   v_d_i/d_d_i : upstream valid/data presented to this stage
//   v_o/d_o     : registered valid/data of this stage
module flop_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             adv_i,
  input  logic             v_d_i,
  input  logic [WIDTH-1:0] d_d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q;
  logic [WIDTH-1:0] d_q;

  // Valid bit: flush wins, otherwise follows upstream whenever the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if (flush_i) begin
      v_q <= 1'b0;
    end else if (adv_i) begin
      v_q <= v_d_i;
    end else begin
      v_q <= v_q;
    end
  end

  // Data register: loads only together with a valid word, so bubbles never overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= {WIDTH{1'b0}};
    end else if (adv_i && v_d_i && !flush_i) begin
      d_q <= d_d_i;
    end else begin
      d_q <= d_q;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data is the write word
//   out_valid/out_ready : downstream handshake, out_data is the read word (from flops)
//   flush               : synchronous clear of every stage's valid bit
//   count               : occupancy register, only with FLOP_PIPE_COUNT_EN defined
// Optional feature macro: FLOP_PIPE_COUNT_EN (adds the count port and its counter).
module flop_pipe
  import flop_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data
`ifdef FLOP_PIPE_COUNT_EN
  ,
  output logic [cnt_width(DEPTH)-1:0] count
`endif
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_param_err
    $error("flop_pipe: WIDTH or DEPTH out of range");
  end

  logic             v_q    [DEPTH];
  logic [WIDTH-1:0] d_q    [DEPTH];
  logic             v_in_s [DEPTH];
  logic [WIDTH-1:0] d_in_s [DEPTH];
  logic [DEPTH-1:0] adv_s;
  logic             in_xfer_s;

  // Advance chain from the output end: a stage moves if the next one is empty or moves too.
  always_comb begin
    logic go_s;
    adv_s = {DEPTH{1'b0}};
    go_s  = out_ready | ~v_q[DEPTH-1];
    adv_s[DEPTH-1] = go_s;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      go_s     = ~v_q[i+1] | go_s;
      adv_s[i] = go_s;
    end
  end

  assign in_ready  = (~v_q[0] | adv_s[0]) & ~flush;
  assign in_xfer_s = in_valid & in_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign v_in_s[g] = in_xfer_s;
      assign d_in_s[g] = in_data;
    end else begin : g_body
      assign v_in_s[g] = v_q[g-1];
      assign d_in_s[g] = d_q[g-1];
    end

    flop_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush_i(flush),
      .adv_i  (adv_s[g]),
      .v_d_i  (v_in_s[g]),
      .d_d_i  (d_in_s[g]),
      .v_o    (v_q[g]),
      .d_o    (d_q[g])
    );
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

`ifdef FLOP_PIPE_COUNT_EN
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic          out_xfer_s;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  assign out_xfer_s = v_q[DEPTH-1] & out_ready;

  // Occupancy next state: simultaneous in/out transfers cancel out.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {CW{1'b0}};
    end else if (in_xfer_s && !out_xfer_s) begin
      count_d = count_q + CNT_ONE;
    end else if (out_xfer_s && !in_xfer_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_flop_pipe.sv
// tb_flop_pipe: vector table plus directed sequences for flop_pipe, with a
// scoreboard queue per instance (8x4 pipe and 1x1 pipe).
module tb_flop_pipe;

  logic clk;
  logic rst_n;

  logic       iv1, ir1, fl1, ov1, or1;
  logic [7:0] id1, od1;
  logic       iv2, ir2, fl2, ov2, or2;
  logic       id2, od2;
`ifdef FLOP_PIPE_COUNT_EN
  logic [2:0] cnt1;
  logic       cnt2;
`endif

  int n_cmp;
  int n_bad;
  logic [7:0] q1[$];
  logic       q2[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic       chk_d;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

  flop_pipe #(.WIDTH(8), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .flush(fl1), .out_valid(ov1), .out_ready(or1), .out_data(od1)
`ifdef FLOP_PIPE_COUNT_EN
    , .count(cnt1)
`endif
  );

  flop_pipe #(.WIDTH(1), .DEPTH(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .flush(fl2), .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef FLOP_PIPE_COUNT_EN
    , .count(cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic addv(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                      input logic e_ir, input logic e_ov, input logic chk_d,
                      input logic [7:0] e_od, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.e_ir = e_ir; v.e_ov = e_ov;
    v.chk_d = chk_d; v.e_od = e_od; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Called at the falling edge: handshakes seen now complete at the next rising edge.
  task automatic sb_update();
    logic [7:0] e1;
    logic       e2;
    if (ov1 && or1) begin
      chk("sb1_has_expected", 64'(q1.size() != 0), 64'(1'b1));
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("sb1_data", 64'(od1), 64'(e1));
      end
    end
    if (fl1) q1.delete();
    if (iv1 && ir1) q1.push_back(id1);
    if (ov2 && or2) begin
      chk("sb2_has_expected", 64'(q2.size() != 0), 64'(1'b1));
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        chk("sb2_data", 64'(od2), 64'(e2));
      end
    end
    if (fl2) q2.delete();
    if (iv2 && ir2) q2.push_back(id2);
  endtask

  task automatic cycle_end();
    sb_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    iv1 = 1'b0; id1 = 8'h00; fl1 = 1'b0; or1 = 1'b0;
    iv2 = 1'b0; id2 = 1'b0;  fl2 = 1'b0; or2 = 1'b0;

    // three words back to back, out_ready high
    addv(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
    addv(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
    addv(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3'd3);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 3'd2);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 3'd1);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    // backpressure: five words offered, four fit, fifth enters with the first out_ready
    addv(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    addv(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
    addv(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2);
    addv(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3);
    addv(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd4);
    addv(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd4);
    addv(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd4);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd4);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd3);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd2);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1);
    addv(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(ov1), 64'(1'b0));
    chk("rst_out_data", 64'(od1), 64'(8'h00));
    chk("rst_in_ready", 64'(ir1), 64'(1'b1));
    chk("rst_out_valid_d1", 64'(ov2), 64'(1'b0));
`ifdef FLOP_PIPE_COUNT_EN
    chk("rst_count", 64'(cnt1), 64'(3'd0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table-driven vectors
    for (int r = 0; r < vecs.size(); r++) begin
      iv1 = vecs[r].iv; id1 = vecs[r].d; or1 = vecs[r].ordy; fl1 = vecs[r].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", r), 64'(ir1), 64'(vecs[r].e_ir));
      chk($sformatf("vec%0d_out_valid", r), 64'(ov1), 64'(vecs[r].e_ov));
      if (vecs[r].chk_d) chk($sformatf("vec%0d_out_data", r), 64'(od1), 64'(vecs[r].e_od));
`ifdef FLOP_PIPE_COUNT_EN
      chk($sformatf("vec%0d_count", r), 64'(cnt1), 64'(vecs[r].e_cnt));
`endif
      cycle_end();
    end

    // full pipe streaming: fill with out_ready low, then 10 cycles in and out together
    iv1 = 1'b1; or1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id1 = 8'hB0 + 8'(i);
      @(negedge clk);
      chk("fill_in_ready", 64'(ir1), 64'(1'b1));
      cycle_end();
    end
    or1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      id1 = 8'hC0 + 8'(i);
      @(negedge clk);
      chk("stream_in_ready", 64'(ir1), 64'(1'b1));
      chk("stream_out_valid", 64'(ov1), 64'(1'b1));
`ifdef FLOP_PIPE_COUNT_EN
      chk("stream_count", 64'(cnt1), 64'(3'd4));
`endif
      cycle_end();
    end
    iv1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      cycle_end();
    end
    chk("stream_drained", 64'(q1.size()), 64'(0));

    // flush a word sitting in stage 0
    iv1 = 1'b1; id1 = 8'hA5;
    @(negedge clk);
    chk("flush_load_ready", 64'(ir1), 64'(1'b1));
    cycle_end();
    iv1 = 1'b0; fl1 = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(ir1), 64'(1'b0));
    cycle_end();
    fl1 = 1'b0;
    @(negedge clk);
    chk("post_flush_out_valid", 64'(ov1), 64'(1'b0));
    chk("post_flush_in_ready", 64'(ir1), 64'(1'b1));
`ifdef FLOP_PIPE_COUNT_EN
    chk("post_flush_count", 64'(cnt1), 64'(3'd0));
`endif
    cycle_end();
    repeat (6) begin
      @(negedge clk);
      chk("flush_no_output", 64'(ov1), 64'(1'b0));
      cycle_end();
    end

    // asynchronous reset with three words stored
    or1 = 1'b0; iv1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id1 = 8'hD1 + 8'(i);
      @(negedge clk);
      cycle_end();
    end
    iv1 = 1'b0;
    @(negedge clk);
    cycle_end();
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(ov1), 64'(1'b1));
    chk("pre_rst_out_data", 64'(od1), 64'(8'hD1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(ov1), 64'(1'b0));
    chk("async_rst_out_data", 64'(od1), 64'(8'h00));
`ifdef FLOP_PIPE_COUNT_EN
    chk("async_rst_count", 64'(cnt1), 64'(3'd0));
`endif
    q1.delete();
    q2.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("in_rst_in_ready", 64'(ir1), 64'(1'b1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or1 = 1'b1; iv1 = 1'b1; id1 = 8'hE1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(ov1), 64'(1'b0));
    cycle_end();
    iv1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      cycle_end();
    end
    chk("post_rst_drained", 64'(q1.size()), 64'(0));

    // single-stage 1-bit pipe under random handshakes
    for (int i = 0; i < 200; i++) begin
      iv2 = 1'($urandom_range(1, 0));
      id2 = 1'($urandom_range(1, 0));
      or2 = 1'($urandom_range(1, 0));
      @(negedge clk);
      chk("d1_in_ready", 64'(ir2), 64'(!ov2 || or2));
      cycle_end();
    end
    iv2 = 1'b0; or2 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      cycle_end();
    end
    chk("d1_drained", 64'(q2.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
